reload_down_counter: RTL and testbench

- Programmable down-counter/timer. It is the counting-down counterpart of the team's 8-bit preset up-counter.
- Takes a start value over a valid/ready load handshake. Decrements at a prescaled rate. Emits a one-cycle terminal-count pulse on reaching zero.
- Supports one-shot and auto-reload modes.
- Sits beside the up-counter in the user project area as the interval/timeout source driven by the same load-value bus.

---
 rtl/reload_down_counter_pkg.sv | 21 ++
 rtl/reload_down_counter_prescaler_tick.sv | 39 +++
 rtl/reload_down_counter.sv | 124 ++++++++++++
 tb/tb_reload_down_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/reload_down_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : reload_down_counter_pkg                                     |
// | Brief  : Shared types and default widths for the preset up-counter   |
// |          and the reload down-counter.                                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package reload_down_counter_pkg;

  // Counter and prescaler default widths, common to both counters
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PS_WIDTH = 8;

  // Two-state controller: waiting for load/start, or counting
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : reload_down_counter_pkg
`default_nettype wire

// File: rtl/reload_down_counter_prescaler_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prescaler_tick                                              |
// | Brief  : Free-running prescaler; raises tick for one cycle every     |
// |          prescale+1 enabled cycles. prescale is compared live, so a  |
// |          shrinking value lets the counter wrap before the next tick. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module prescaler_tick #(
  parameter int PS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic                tick
);

  logic [PS_WIDTH-1:0] r_ps_cnt;

  // The tick is combinational so the parent can act on it in the same edge
  assign tick = enable && (r_ps_cnt == prescale);

  // Count enabled cycles; restart on a tick or whenever the parent clears
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_ps_cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        r_ps_cnt <= '0;
      end else begin
        r_ps_cnt <= r_ps_cnt + PS_WIDTH'(1);
      end
    end
  end

endmodule : prescaler_tick
`default_nettype wire

// File: rtl/reload_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : reload_down_counter                                         |
// | Brief  : Programmable down-counter / timer with valid/ready load,    |
// |          prescaled decrement, one-shot or auto-reload operation and  |
// |          a one-cycle terminal-count strobe.                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module reload_down_counter
  import reload_down_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PS_WIDTH = DEFAULT_PS_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                start,
  input  logic                stop,
  input  logic                auto_reload,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                tc_pulse
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_next;
  logic             r_tc;
  logic             w_tc_next;
  logic             w_tick;
  logic             w_ps_enable;
  logic             w_ps_clear;

  // Prescaler runs only while counting; it is held at zero in IDLE so that
  // entry into RUN always starts a full prescale+1 interval. A stop edge
  // also clears it.
  assign w_ps_enable = (r_state == ST_RUN) && !stop;
  assign w_ps_clear  = (r_state == ST_IDLE) || stop;

  prescaler_tick #(
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler_tick (
    .clk      (clk),
    .reset    (reset),
    .enable   (w_ps_enable),
    .clear    (w_ps_clear),
    .prescale (prescale),
    .tick     (w_tick)
  );

  // Next-state, counter, reload register and strobe decisions
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A load wins over start; start must come back on a later cycle
        if (load_valid) begin
          w_count_next  = load_value;
          w_reload_next = load_value;
        end else if (start && !stop && (r_count != '0)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop freezes the count even if a tick lands on the same edge
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_tick) begin
          if (r_count == WIDTH'(1)) begin
            w_tc_next = 1'b1;
            if (auto_reload && (r_reload != '0)) begin
              w_count_next = r_reload;
            end else begin
              w_count_next = '0;
              w_state_next = ST_IDLE;
            end
          end else begin
            w_count_next = r_count - WIDTH'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, counter, reload value and terminal strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
    end
  end

  assign count      = r_count;
  assign tc_pulse   = r_tc;
  assign busy       = (r_state == ST_RUN);
  assign load_ready = (r_state == ST_IDLE);

  // RUN is entered only with a non-zero count and is left on reaching zero,
  // so a tick can never see a zero count while running.
  a_no_underflow : assert property (
    @(posedge clk) disable iff (reset)
    !((r_state == ST_RUN) && w_tick && !stop && (r_count == '0))
  );

endmodule : reload_down_counter
`default_nettype wire

// File: tb/tb_reload_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_reload_down_counter                                      |
// | Brief  : Directed scoreboard bench for reload_down_counter.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_reload_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_value;
  logic       load_valid;
  logic       load_ready;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] prescale;
  logic [7:0] count;
  logic       busy;
  logic       tc_pulse;

  typedef struct {
    logic [7:0] cnt;
    logic       bsy;
    logic       tc;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reload_down_counter #(
    .WIDTH    (8),
    .PS_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_value  (load_value),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .tc_pulse    (tc_pulse)
  );

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected just after the following rising edge.
  task automatic cyc(input logic rst, input logic lv, input logic [7:0] lval,
                     input logic st, input logic sp, input logic ar,
                     input logic [7:0] ps, input logic [7:0] ec,
                     input logic eb, input logic et, input logic er,
                     input string nm);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    load_valid  = lv;
    load_value  = lval;
    start       = st;
    stop        = sp;
    auto_reload = ar;
    prescale    = ps;
    e.cnt = ec; e.bsy = eb; e.tc = et; e.rdy = er; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare outputs with the oldest entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({count, busy, tc_pulse, load_ready} !== {e.cnt, e.bsy, e.tc, e.rdy}) begin
          n_fail++;
          $display("FAIL %s: got count=%0d busy=%b tc=%b ready=%b, expected count=%0d busy=%b tc=%b ready=%b",
                   e.nm, count, busy, tc_pulse, load_ready, e.cnt, e.bsy, e.tc, e.rdy);
        end
      end
    end
  end

  initial begin
    int t;
    logic [7:0] ev;
    reset = 1'b1; load_valid = 1'b0; load_value = '0; start = 1'b0;
    stop = 1'b0; auto_reload = 1'b0; prescale = '0;

    // Reset state
    cyc(1, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, "reset");
    cyc(1, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, "reset_hold");

    // start with count 0 is ignored
    cyc(0, 0, 8'd0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 1, "start_zero");
    cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, "start_zero_after");

    // One-shot, prescale 0: 5,4,3,2,1,0
    cyc(0, 1, 8'd5, 0, 0, 0, 8'd0, 8'd5, 0, 0, 1, "os_load");
    cyc(0, 0, 8'd0, 1, 0, 0, 8'd0, 8'd5, 1, 0, 0, "os_start");
    for (int k = 4; k >= 1; k--)
      cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'(k), 1, 0, 0, "os_dec");
    cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, "os_tc");
    cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, "os_tc_one_cycle");

    // Auto-reload 3 with prescale 2: 3,2,1,3,... tc every 9 cycles
    cyc(0, 1, 8'd3, 0, 0, 1, 8'd2, 8'd3, 0, 0, 1, "ar_load");
    cyc(0, 0, 8'd0, 1, 0, 1, 8'd2, 8'd3, 1, 0, 0, "ar_start");
    for (int k = 1; k <= 20; k++) begin
      t  = k / 3;
      ev = 8'(3 - (t % 3));
      cyc(0, 0, 8'd0, 0, 0, 1, 8'd2, ev, 1, (k % 9) == 0, 0, "ar_run");
    end
    // stop on a cycle whose tick would fire: count holds at 3
    cyc(0, 0, 8'd0, 0, 1, 1, 8'd2, 8'd3, 0, 0, 1, "ar_stop_on_tick");

    // Stop after 4 decrements, then resume from the held value
    cyc(0, 1, 8'd10, 0, 0, 0, 8'd0, 8'd10, 0, 0, 1, "sr_load");
    cyc(0, 0, 8'd0, 1, 0, 0, 8'd0, 8'd10, 1, 0, 0, "sr_start");
    for (int k = 9; k >= 6; k--)
      cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'(k), 1, 0, 0, "sr_dec");
    cyc(0, 0, 8'd0, 0, 1, 0, 8'd0, 8'd6, 0, 0, 1, "sr_stop");
    cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'd6, 0, 0, 1, "sr_hold");
    cyc(0, 0, 8'd0, 1, 0, 0, 8'd0, 8'd6, 1, 0, 0, "sr_restart");
    for (int k = 5; k >= 1; k--)
      cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'(k), 1, 0, 0, "sr_resume");
    cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, "sr_tc");

    // Load presented during RUN waits until IDLE
    cyc(0, 1, 8'd4, 0, 0, 0, 8'd0, 8'd4, 0, 0, 1, "lr_load");
    cyc(0, 0, 8'd0, 1, 0, 0, 8'd0, 8'd4, 1, 0, 0, "lr_start");
    for (int k = 3; k >= 1; k--)
      cyc(0, 1, 8'h55, 0, 0, 0, 8'd0, 8'(k), 1, 0, 0, "lr_blocked");
    cyc(0, 1, 8'h55, 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, "lr_tc");
    cyc(0, 1, 8'h55, 0, 0, 0, 8'd0, 8'h55, 0, 0, 1, "lr_accept");

    // start together with stop in IDLE stays IDLE
    cyc(0, 0, 8'd0, 1, 1, 0, 8'd0, 8'h55, 0, 0, 1, "start_stop_idle");

    // load together with start takes only the load
    cyc(0, 1, 8'd7, 1, 0, 0, 8'd0, 8'd7, 0, 0, 1, "load_start");
    cyc(0, 0, 8'd0, 0, 0, 0, 8'd0, 8'd7, 0, 0, 1, "load_start_after");

    // Reset while running at count 7
    cyc(0, 0, 8'd0, 1, 0, 0, 8'd0, 8'd7, 1, 0, 0, "mr_start");
    cyc(1, 0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, "mr_reset");
    cyc(0, 0, 8'd0, 1, 0, 1, 8'd0, 8'd0, 0, 0, 1, "mr_start_zero");

    // Let the monitor consume the last entry, then confirm nothing is left
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reload_down_counter
`default_nettype wire
